sangdan_monitor: RTL and testbench
==================================

SANGDAN_MONITOR -- requirements
Module: sangdan_monitor

Interface
REQ-001 Parameter HOLD_OK, default 0: when 1, a repeated pattern on a TICK in LOCKED is accepted without error.
REQ-002 Parameter LOCK_LOSS, default 2, range 1..7: consecutive mismatches in LOCKED that return the block to HUNT.
REQ-003 CLK  input  1  sole clock; all logic on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 TICK  input  1  sample strobe; Q_IN is evaluated only on cycles with TICK=1 (tie high when CLK is the pattern clock).
REQ-006 Q_IN  input  8  LED bus driven by the fill/clear chaser.
REQ-007 LOCKED  output  1  1 while the tracker is in state LOCKED.
REQ-008 STEP  output  4  index 0..15 of the last legal pattern accepted.
REQ-009 LEVEL  output  4  number of ones in the last legal pattern (0..8).
REQ-010 PHASE  output  1  0 for fill (STEP 0..8), 1 for clear (STEP 9..15).
REQ-011 ERR  output  1  one-cycle pulse per mismatch detected in LOCKED.
REQ-012 ERR_CNT  output  8  mismatch count, saturating at 255.
REQ-013 WRAP  output  1  one-cycle pulse when LOCKED accepts STEP 15 -> 0.

Function
REQ-014 Legal sequence: index 0..8 = 0x00,0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F,0xFF; index 9..15 = 0xFE,0xFC,0xF8,0xF0,0xE0,0xC0,0x80; after 15 the sequence returns to 0.
REQ-015 Each legal pattern maps to exactly one index; any other byte is illegal.
REQ-016 Expected pattern = index (STEP+1) mod 16.
REQ-017 States: HUNT, VERIFY, LOCKED; all state changes occur only on TICK cycles.
REQ-018 HUNT: a legal Q_IN loads STEP/LEVEL/PHASE and moves to VERIFY; an illegal Q_IN stays in HUNT with outputs unchanged.
REQ-019 VERIFY: Q_IN equal to the expected pattern advances STEP and moves to LOCKED.
REQ-020 VERIFY: any other legal Q_IN reloads STEP and stays in VERIFY; an illegal Q_IN moves to HUNT.
REQ-021 HUNT and VERIFY never raise ERR and never change ERR_CNT.
REQ-022 LOCKED, Q_IN equals the expected pattern: STEP advances, the miss counter clears, and WRAP pulses when STEP goes 15 -> 0.
REQ-023 LOCKED, Q_IN equals the current pattern with HOLD_OK=1: no change and no error.
REQ-024 LOCKED, Q_IN equals the current pattern with HOLD_OK=0: treated as a mismatch.
REQ-025 LOCKED mismatch actions:
  - ERR pulses; ERR_CNT increments, saturating at 255; the miss counter increments.
  - A legal Q_IN resyncs STEP/LEVEL/PHASE to that pattern; an illegal Q_IN leaves them unchanged.
REQ-026 LOCKED: when the miss counter reaches LOCK_LOSS on a mismatch, the block moves to HUNT in the same update; LOCKED drops the next cycle.
REQ-027 All outputs are registered; each output reflects a TICK sample exactly 1 CLK later.
REQ-028 ERR and WRAP are high for one cycle only, even when TICK is held high.
REQ-029 LEVEL always equals the popcount of the pattern indexed by STEP.
REQ-030 TICK=0: all state and outputs hold, except that ERR and WRAP return to 0.

Reset
REQ-031 RST=1 at a clock edge forces, on that edge:
  - state HUNT and miss counter 0;
  - LOCKED, STEP, LEVEL, PHASE, ERR, WRAP all 0; ERR_CNT = 0.
REQ-032 RST has priority over TICK; asserting RST mid-sequence discards the lock, and re-lock requires two legal consecutive samples.

Verification
REQ-033 TICK=1, Q_IN = 0x00,0x01,0x03 -> LOCKED=1 one cycle after the 0x01 sample; STEP=2, LEVEL=2, PHASE=0 after 0x03.
REQ-034 Locked, full 16-pattern cycle 0x80 -> 0x00 -> WRAP one cycle high, STEP=0, ERR_CNT unchanged.
REQ-035 Locked at STEP 4 (0x0F), inject 0x3C then 0x1F, LOCK_LOSS=2 -> ERR pulse and ERR_CNT=1 after 0x3C (STEP stays 4); 0x1F matches the expected pattern, clears the miss counter and stays LOCKED at STEP 5.
REQ-036 Locked, inject 0x55 twice, LOCK_LOSS=2 -> ERR_CNT=2 and LOCKED=0 after the second sample; the following 0x07,0x0F re-locks with STEP=4.
REQ-037 HOLD_OK=0 versus 1, locked at 0xFF, repeat 0xFF -> ERR=1 for HOLD_OK=0; no ERR and STEP=8 for HOLD_OK=1.
REQ-038 Force 300 mismatches, then RST=1 for one cycle -> ERR_CNT saturates at 255, then returns to 0 with all outputs 0.

Source files
------------

// File: rtl/sangdan_monitor.sv
// Tracks the 16-step fill/clear LED chaser on Q_IN, locks onto it and reports mismatches.
// All outputs are registered; state only moves on TICK cycles.
module sangdan_monitor #(
  parameter bit          HOLD_OK   = 1'b0,
  parameter int unsigned LOCK_LOSS = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic [7:0] Q_IN,
  output logic       LOCKED,
  output logic [3:0] STEP,
  output logic [3:0] LEVEL,
  output logic       PHASE,
  output logic       ERR,
  output logic [7:0] ERR_CNT,
  output logic       WRAP
);

  localparam logic [2:0] LossThr = 3'(LOCK_LOSS);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e     state_q;
  logic [2:0] miss_q;

  // Index 0..8 fills from bit 0 upward, 9..15 clears from bit 0 upward.
  function automatic logic [7:0] pat_of(input logic [3:0] idx);
    logic [8:0] f;
    if (idx <= 4'd8) begin
      f = (9'd1 << idx) - 9'd1;
      return f[7:0];
    end
    return 8'hFF << (idx - 4'd8);
  endfunction

  function automatic logic [3:0] level_of(input logic [3:0] idx);
    logic [4:0] l;
    l = (idx <= 4'd8) ? {1'b0, idx} : 5'd16 - {1'b0, idx};
    return l[3:0];
  endfunction

  logic       in_legal;
  logic [3:0] in_idx;
  logic [3:0] step_next;
  logic [7:0] exp_pat;
  logic [7:0] cur_pat;
  logic [2:0] miss_inc;

  always_comb begin
    in_legal = 1'b0;
    in_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (Q_IN == pat_of(4'(i))) begin
        in_legal = 1'b1;
        in_idx   = 4'(i);
      end
    end
    step_next = STEP + 4'd1;
    exp_pat   = pat_of(step_next);
    cur_pat   = pat_of(STEP);
    miss_inc  = miss_q + 3'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StHunt;
      miss_q  <= 3'd0;
      LOCKED  <= 1'b0;
      STEP    <= 4'd0;
      LEVEL   <= 4'd0;
      PHASE   <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= 8'd0;
      WRAP    <= 1'b0;
    end else begin
      ERR  <= 1'b0;
      WRAP <= 1'b0;
      if (TICK) begin
        unique case (state_q)
          StHunt: begin
            if (in_legal) begin
              STEP    <= in_idx;
              LEVEL   <= level_of(in_idx);
              PHASE   <= (in_idx >= 4'd9);
              state_q <= StVerify;
            end
          end
          StVerify: begin
            if (Q_IN == exp_pat) begin
              STEP    <= step_next;
              LEVEL   <= level_of(step_next);
              PHASE   <= (step_next >= 4'd9);
              miss_q  <= 3'd0;
              state_q <= StLocked;
              LOCKED  <= 1'b1;
            end else if (in_legal) begin
              STEP  <= in_idx;
              LEVEL <= level_of(in_idx);
              PHASE <= (in_idx >= 4'd9);
            end else begin
              state_q <= StHunt;
            end
          end
          StLocked: begin
            if (Q_IN == exp_pat) begin
              STEP   <= step_next;
              LEVEL  <= level_of(step_next);
              PHASE  <= (step_next >= 4'd9);
              miss_q <= 3'd0;
              WRAP   <= (STEP == 4'd15);
            end else if (!(HOLD_OK && (Q_IN == cur_pat))) begin
              ERR <= 1'b1;
              if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
              if (in_legal) begin
                STEP  <= in_idx;
                LEVEL <= level_of(in_idx);
                PHASE <= (in_idx >= 4'd9);
              end
              // Too many consecutive misses: drop back to hunting in this same update.
              if (miss_inc >= LossThr) begin
                miss_q  <= 3'd0;
                state_q <= StHunt;
                LOCKED  <= 1'b0;
              end else begin
                miss_q <= miss_inc;
              end
            end
          end
          default: begin
            state_q <= StHunt;
            LOCKED  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sangdan_monitor.sv
// Directed bench for sangdan_monitor; two instances differ only in HOLD_OK.
module tb_sangdan_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK;
  logic [7:0] Q_IN;

  logic       a_locked, a_phase, a_err, a_wrap;
  logic [3:0] a_step, a_level;
  logic [7:0] a_err_cnt;
  logic       b_locked, b_phase, b_err, b_wrap;
  logic [3:0] b_step, b_level;
  logic [7:0] b_err_cnt;

  sangdan_monitor #(.HOLD_OK(1'b0), .LOCK_LOSS(2)) dut_a (
    .CLK(CLK), .RST(RST), .TICK(TICK), .Q_IN(Q_IN),
    .LOCKED(a_locked), .STEP(a_step), .LEVEL(a_level), .PHASE(a_phase),
    .ERR(a_err), .ERR_CNT(a_err_cnt), .WRAP(a_wrap)
  );

  sangdan_monitor #(.HOLD_OK(1'b1), .LOCK_LOSS(2)) dut_b (
    .CLK(CLK), .RST(RST), .TICK(TICK), .Q_IN(Q_IN),
    .LOCKED(b_locked), .STEP(b_step), .LEVEL(b_level), .PHASE(b_phase),
    .ERR(b_err), .ERR_CNT(b_err_cnt), .WRAP(b_wrap)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  logic [7:0] pat [16];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [7:0] q);
    TICK = 1'b1;
    Q_IN = q;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    TICK = 1'b1;
    Q_IN = 8'h01;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a_out"}, {a_locked, a_step, a_level, a_phase, a_err, a_err_cnt, a_wrap}, 0);
    check_eq({tag, "_b_out"}, {b_locked, b_step, b_level, b_phase, b_err, b_err_cnt, b_wrap}, 0);
  endtask

  initial begin
    pat = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    RST  = 1'b0;
    TICK = 1'b0;
    Q_IN = 8'h00;
    @(posedge CLK);
    #1;

    do_reset();
    check_all_zero("reset");

    tick(8'h55);
    check_eq("hunt_illegal_locked", a_locked, 0);
    check_eq("hunt_illegal_step", a_step, 0);

    // Initial lock
    tick(8'h00);
    check_eq("verify_locked", a_locked, 0);
    tick(8'h01);
    check_eq("lock_locked", a_locked, 1);
    check_eq("lock_step", a_step, 1);
    tick(8'h03);
    check_eq("s2_step", a_step, 2);
    check_eq("s2_level", a_level, 2);
    check_eq("s2_phase", a_phase, 0);

    for (int i = 3; i < 16; i++) begin
      tick(pat[i]);
      if (i == 12) begin
        check_eq("s12_step", a_step, 12);
        check_eq("s12_level", a_level, 4);
        check_eq("s12_phase", a_phase, 1);
      end
    end
    tick(8'h00);
    check_eq("wrap_pulse", a_wrap, 1);
    check_eq("wrap_step", a_step, 0);
    check_eq("wrap_level", a_level, 0);
    check_eq("wrap_err_cnt", a_err_cnt, 0);

    // TICK low: state holds, garbage on the bus ignored
    TICK = 1'b0;
    Q_IN = 8'h55;
    @(posedge CLK);
    #1;
    check_eq("idle_wrap", a_wrap, 0);
    check_eq("idle_err", a_err, 0);
    check_eq("idle_step", a_step, 0);
    check_eq("idle_locked", a_locked, 1);

    tick(8'h01);
    tick(8'h03);
    tick(8'h07);
    tick(8'h0F);
    check_eq("s4_step", a_step, 4);
    tick(8'h3C);
    check_eq("miss_err", a_err, 1);
    check_eq("miss_cnt", a_err_cnt, 1);
    check_eq("miss_step", a_step, 4);
    check_eq("miss_locked", a_locked, 1);
    tick(8'h1F);
    check_eq("recover_err", a_err, 0);
    check_eq("recover_step", a_step, 5);
    check_eq("recover_locked", a_locked, 1);
    check_eq("recover_cnt", a_err_cnt, 1);

    // Lock loss after two consecutive misses, then re-lock
    do_reset();
    tick(8'h00);
    tick(8'h01);
    tick(8'h55);
    check_eq("loss1_err", a_err, 1);
    check_eq("loss1_cnt", a_err_cnt, 1);
    check_eq("loss1_locked", a_locked, 1);
    tick(8'h55);
    check_eq("loss2_err", a_err, 1);
    check_eq("loss2_cnt", a_err_cnt, 2);
    check_eq("loss2_locked", a_locked, 0);
    tick(8'h07);
    check_eq("relock_v_locked", a_locked, 0);
    check_eq("relock_v_step", a_step, 3);
    tick(8'h0F);
    check_eq("relock_locked", a_locked, 1);
    check_eq("relock_step", a_step, 4);
    check_eq("relock_err", a_err, 0);

    // Repeated pattern at 0xFF: error only without HOLD_OK
    tick(8'h1F);
    tick(8'h3F);
    tick(8'h7F);
    tick(8'hFF);
    check_eq("ff_a_step", a_step, 8);
    check_eq("ff_b_step", b_step, 8);
    tick(8'hFF);
    check_eq("hold0_err", a_err, 1);
    check_eq("hold0_cnt", a_err_cnt, 3);
    check_eq("hold1_err", b_err, 0);
    check_eq("hold1_step", b_step, 8);
    check_eq("hold1_locked", b_locked, 1);
    check_eq("hold1_cnt", b_err_cnt, 2);
    tick(8'hFE);
    check_eq("after_hold_a_step", a_step, 9);
    check_eq("after_hold_a_phase", a_phase, 1);
    check_eq("after_hold_a_locked", a_locked, 1);

    // 300 mismatches: 150 rounds of lock + two misses
    do_reset();
    for (int r = 0; r < 150; r++) begin
      tick(8'h00);
      tick(8'h01);
      tick(8'h55);
      tick(8'h55);
      if (r == 126) check_eq("sat_pre_cnt", a_err_cnt, 254);
    end
    check_eq("sat_a_cnt", a_err_cnt, 255);
    check_eq("sat_b_cnt", b_err_cnt, 255);
    do_reset();
    check_all_zero("final_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
